// File: rtl/can_bit_stuffer.sv
// CAN bit stuffer: forwards NRZ frame bits to the TX line and inserts a
// complementary stuff bit after STUFF_LEN equal bits inside the stuffing region.
module can_bit_stuffer #(
    parameter  int STUFF_LEN = 5,
    localparam int CNT_W     = $clog2(STUFF_LEN + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_point,
    input  logic       frame_start,
    input  logic       stuff_en,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_bit,
    output logic       stuff_active,
    output logic [7:0] stuff_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        STUFF
    } state_e;

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STUFF_LEN);

    state_e           state_q;
    logic             out_bit_q;
    logic             stuff_active_q;
    logic [7:0]       stuff_cnt_q;
    logic [CNT_W-1:0] run_cnt_q;
    logic             last_bit_q;
    logic             pending_q;

    logic             xfer;
    logic [CNT_W-1:0] run_d;
    logic [7:0]       stuff_cnt_d;
    logic [7:0]       stuff_base;

    assign in_ready     = ~pending_q;
    assign out_bit      = out_bit_q;
    assign stuff_active = stuff_active_q;
    assign stuff_cnt    = stuff_cnt_q;

    assign xfer = sample_point & in_valid & ~pending_q;

    // Run length after accepting in_bit; a new frame always starts a fresh run.
    always_comb begin
        run_d = CNT_W'(1);
        if (!frame_start && (in_bit == last_bit_q)) begin
            if (run_cnt_q >= RUN_MAX) begin
                run_d = RUN_MAX;
            end else begin
                run_d = run_cnt_q + CNT_W'(1);
            end
        end
    end

    // Saturating count of stuff bits emitted in the current frame.
    always_comb begin
        stuff_base  = frame_start ? 8'd0 : stuff_cnt_q;
        stuff_cnt_d = (stuff_base == 8'hFF) ? 8'hFF : stuff_base + 8'd1;
    end

    // Bit-time FSM; every register advances only on a sample point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            out_bit_q      <= 1'b1;
            stuff_active_q <= 1'b0;
            stuff_cnt_q    <= 8'd0;
            run_cnt_q      <= '0;
            last_bit_q     <= 1'b1;
            pending_q      <= 1'b0;
        end else if (sample_point) begin
            case (state_q)
                STUFF: begin
                    if (frame_start) begin
                        state_q        <= IDLE;
                        out_bit_q      <= 1'b1;
                        stuff_active_q <= 1'b0;
                        stuff_cnt_q    <= 8'd0;
                        run_cnt_q      <= '0;
                        last_bit_q     <= 1'b1;
                        pending_q      <= 1'b0;
                    end else begin
                        state_q        <= SEND;
                        out_bit_q      <= ~last_bit_q;
                        stuff_active_q <= 1'b1;
                        stuff_cnt_q    <= stuff_cnt_d;
                        run_cnt_q      <= CNT_W'(1);
                        last_bit_q     <= ~last_bit_q;
                        pending_q      <= 1'b0;
                    end
                end
                default: begin
                    if (xfer) begin
                        out_bit_q      <= in_bit;
                        stuff_active_q <= 1'b0;
                        run_cnt_q      <= run_d;
                        last_bit_q     <= in_bit;
                        if (frame_start) begin
                            stuff_cnt_q <= 8'd0;
                        end
                        if (stuff_en && (run_d == RUN_MAX)) begin
                            pending_q <= 1'b1;
                            state_q   <= STUFF;
                        end else begin
                            pending_q <= 1'b0;
                            state_q   <= SEND;
                        end
                    end else begin
                        state_q        <= IDLE;
                        out_bit_q      <= 1'b1;
                        stuff_active_q <= 1'b0;
                        run_cnt_q      <= '0;
                        last_bit_q     <= 1'b1;
                        pending_q      <= 1'b0;
                        if (frame_start) begin
                            stuff_cnt_q <= 8'd0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_bit_stuffer.sv
// Testbench for can_bit_stuffer: table-driven bit-time vectors plus
// hand-written reset and inter-sample stability sequences.
module tb_can_bit_stuffer;

    logic       clk;
    logic       rst_n;
    logic       sample_point;
    logic       frame_start;
    logic       stuff_en;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       out_bit;
    logic       stuff_active;
    logic [7:0] stuff_cnt;

    int n_tests;
    int n_fail;

    can_bit_stuffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_point (sample_point),
        .frame_start  (frame_start),
        .stuff_en     (stuff_en),
        .in_valid     (in_valid),
        .in_bit       (in_bit),
        .in_ready     (in_ready),
        .out_bit      (out_bit),
        .stuff_active (stuff_active),
        .stuff_cnt    (stuff_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       fs;
        logic       en;
        logic       v;
        logic       b;
        logic       r;
        logic       o;
        logic       sa;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic fs, en, v, b, r, o, sa,
                       input logic [7:0] cnt, input int rep = 1);
        vec_t x;
        x = '{fs: fs, en: en, v: v, b: b, r: r, o: o, sa: sa, cnt: cnt};
        for (int k = 0; k < rep; k++) vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t x, input int idx);
        @(negedge clk);
        frame_start  = x.fs;
        stuff_en     = x.en;
        in_valid     = x.v;
        in_bit       = x.b;
        sample_point = 1'b1;
        #1;
        chk($sformatf("v%0d.ready", idx), {7'd0, in_ready}, {7'd0, x.r});
        @(posedge clk);
        #1;
        sample_point = 1'b0;
        frame_start  = 1'b0;
        chk($sformatf("v%0d.out", idx), {7'd0, out_bit}, {7'd0, x.o});
        chk($sformatf("v%0d.sa", idx), {7'd0, stuff_active}, {7'd0, x.sa});
        chk($sformatf("v%0d.cnt", idx), stuff_cnt, x.cnt);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        sample_point = 1'b0;
        frame_start  = 1'b0;
        stuff_en     = 1'b0;
        in_valid     = 1'b0;
        in_bit       = 1'b1;

        // fs en v b | ready out sa cnt
        // SOF + 0000: stuff 1 after fifth zero
        add(1, 1, 1, 0, 1, 0, 0, 8'd0);
        add(0, 1, 1, 0, 1, 0, 0, 8'd0, 4);
        add(0, 1, 1, 0, 0, 1, 1, 8'd1);
        add(0, 0, 0, 0, 1, 1, 0, 8'd1);
        // idle for ten bit times
        add(0, 0, 0, 0, 1, 1, 0, 8'd1, 10);
        // SOF + eleven 1s
        add(1, 1, 1, 0, 1, 0, 0, 8'd0);
        add(0, 1, 1, 1, 1, 1, 0, 8'd0, 5);
        add(0, 1, 1, 1, 0, 0, 1, 8'd1);
        add(0, 1, 1, 1, 1, 1, 0, 8'd1, 5);
        add(0, 1, 1, 1, 0, 0, 1, 8'd2);
        add(0, 1, 1, 1, 1, 1, 0, 8'd2);
        add(0, 0, 0, 0, 1, 1, 0, 8'd2);
        // 00000 1111 0: stuff bit starts the next run
        add(1, 1, 1, 0, 1, 0, 0, 8'd0);
        add(0, 1, 1, 0, 1, 0, 0, 8'd0, 4);
        add(0, 1, 1, 1, 0, 1, 1, 8'd1);
        add(0, 1, 1, 1, 1, 1, 0, 8'd1, 4);
        add(0, 1, 1, 0, 0, 0, 1, 8'd2);
        add(0, 1, 1, 0, 1, 0, 0, 8'd2);
        add(0, 0, 0, 0, 1, 1, 0, 8'd2);
        // region end: stuff still inserted, then eight 1s unstuffed
        add(1, 1, 1, 0, 1, 0, 0, 8'd0);
        add(0, 1, 1, 0, 1, 0, 0, 8'd0, 4);
        add(0, 0, 1, 1, 0, 1, 1, 8'd1);
        add(0, 0, 1, 1, 1, 1, 0, 8'd1, 8);
        add(0, 0, 0, 0, 1, 1, 0, 8'd1);
        // stuffing disabled: six zeros pass unchanged
        add(1, 0, 1, 0, 1, 0, 0, 8'd0);
        add(0, 0, 1, 0, 1, 0, 0, 8'd0, 5);
        add(0, 0, 0, 0, 1, 1, 0, 8'd0);

        #12;
        chk("rst.out", {7'd0, out_bit}, 8'd1);
        chk("rst.sa", {7'd0, stuff_active}, 8'd0);
        chk("rst.cnt", stuff_cnt, 8'd0);
        chk("rst.ready", {7'd0, in_ready}, 8'd1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        // stability: no sample point, inputs wiggle, outputs hold
        apply('{fs: 1, en: 1, v: 1, b: 0, r: 1, o: 0, sa: 0, cnt: 8'd0}, 900);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = k[0];
            in_bit   = ~k[0];
            #1;
            chk($sformatf("hold%0d.out", k), {7'd0, out_bit}, 8'd0);
            chk($sformatf("hold%0d.ready", k), {7'd0, in_ready}, 8'd1);
        end

        // reset while a stuff bit is pending
        for (int k = 0; k < 4; k++)
            apply('{fs: 0, en: 1, v: 1, b: 0, r: 1, o: 0, sa: 0,
                    cnt: 8'd0}, 910 + k);
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = 1'b0;
        #1;
        chk("pend.ready", {7'd0, in_ready}, 8'd0);
        chk("pend.out", {7'd0, out_bit}, 8'd0);
        rst_n = 1'b0;
        #1;
        chk("mrst.out", {7'd0, out_bit}, 8'd1);
        chk("mrst.ready", {7'd0, in_ready}, 8'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++)
            apply('{fs: 0, en: 1, v: 0, b: 0, r: 1, o: 1, sa: 0,
                    cnt: 8'd0}, 920 + k);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
